// File: rtl/qspi_word_fifo.sv
// qspi_word_fifo: first-word-fall-through word FIFO for the QSPI data path.
// The head word is held in a register so rd_data is stable and resettable.
// Occupancy, watermark and empty/full flags are registered from the next level.
// Overflow/underflow flags are sticky until clr_err_i.
module qspi_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic [AW:0]      level_o,
  input  logic [AW:0]      afull_thr_i,
  input  logic [AW:0]      aempty_thr_i,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             clr_err_i
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wa, ra;

  // Accept logic, pointer/level update, next head word and next flags.
  always_comb begin
    wa        = wr_en_i & (~full_q | rd_en_i) & ~flush_i;
    ra        = rd_en_i & ~empty_q & ~flush_i;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(wa);
      rd_ptr_d = rd_ptr_q + AW'(ra);
      level_d  = level_q + (AW+1)'(wa) - (AW+1)'(ra);
      // The new head is either already stored, or is the word being written
      // right now (write into empty, or pop of the last word with a write).
      if (level_d != '0) begin
        if (wa && (rd_ptr_d == wr_ptr_q))
          rd_data_d = wr_data_i;
        else
          rd_data_d = mem[rd_ptr_d];
      end
    end

    full_d   = (level_d == (AW+1)'(DEPTH));
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= afull_thr_i);
    aempty_d = (level_d <= aempty_thr_i);
    // Events set the flag even when clr_err_i is high in the same cycle.
    ovf_d = (ovf_q & ~clr_err_i) | (wr_en_i & full_q & ~rd_en_i & ~flush_i);
    udf_d = (udf_q & ~clr_err_i) | (rd_en_i & empty_q & ~flush_i);
  end

  // Control and status registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk_i) begin
    if (wa)
      mem[wr_ptr_q] <= wr_data_i;
  end

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign level_o        = level_q;
  assign rd_data_o      = rd_data_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_qspi_word_fifo.sv
// Testbench for qspi_word_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_qspi_word_fifo;
  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic        full_o;
  logic        rd_en_i = 1'b0;
  logic [31:0] rd_data_o;
  logic        empty_o;
  logic [4:0]  level_o;
  logic [4:0]  afull_thr_i = 5'd12;
  logic [4:0]  aempty_thr_i = 5'd2;
  logic        almost_full_o;
  logic        almost_empty_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        clr_err_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_rd;
  logic        m_ovf, m_udf, m_af, m_ae;

  qspi_word_fifo #(.WIDTH(32), .DEPTH(DEPTH), .AW(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .full_o(full_o),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .empty_o(empty_o),
    .level_o(level_o), .afull_thr_i(afull_thr_i), .aempty_thr_i(aempty_thr_i),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .clr_err_i(clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    flush_i = 0; wr_en_i = 0; rd_en_i = 0; clr_err_i = 0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd = '0; m_ovf = 0; m_udf = 0; m_af = 0; m_ae = 1;
  endtask

  // One clock with the current inputs; model follows the FIFO rules directly.
  task automatic cyc();
    int  sz;
    bit  oe, ue;
    @(posedge clk_i);
    #1;
    sz = m_q.size();
    oe = 0; ue = 0;
    if (flush_i) begin
      m_q.delete();
    end else begin
      oe = wr_en_i && (sz == DEPTH) && !rd_en_i;
      ue = rd_en_i && (sz == 0);
      if (rd_en_i && sz > 0) void'(m_q.pop_front());
      if (wr_en_i && (sz < DEPTH || rd_en_i)) m_q.push_back(wr_data_i);
    end
    m_ovf = (m_ovf && !clr_err_i) || oe;
    m_udf = (m_udf && !clr_err_i) || ue;
    if (m_q.size() > 0) m_rd = m_q[0];
    m_af = (m_q.size() >= int'(afull_thr_i));
    m_ae = (m_q.size() <= int'(aempty_thr_i));
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1;
    @(posedge clk_i);
    #1;
    reset_i = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || level_o !== 5'd0 ||
        almost_empty_o !== 1'b1 || almost_full_o !== 1'b0 ||
        overflow_o !== 1'b0 || underflow_o !== 1'b0 || rd_data_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: got e=%b f=%b lvl=%0d ae=%b af=%b ov=%b un=%b rd=%h expected e=1 f=0 lvl=0 ae=1 af=0 ov=0 un=0 rd=0",
               empty_o, full_o, level_o, almost_empty_o, almost_full_o, overflow_o, underflow_o, rd_data_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a[3];
    for (int i = 0; i < 3; i++) a[i] = $urandom;
    wr_en_i = 1; wr_data_i = a[0];
    cyc();
    n_tests++;
    if (empty_o !== 1'b0 || rd_data_o !== a[0]) begin
      n_fail++;
      $display("FAIL basic_first_word: got empty=%b rd=%h expected empty=0 rd=%h", empty_o, rd_data_o, a[0]);
    end
    wr_data_i = a[1]; cyc();
    wr_data_i = a[2]; cyc();
    wr_en_i = 0;
    n_tests++;
    if (level_o !== 5'd3) begin
      n_fail++;
      $display("FAIL basic_level: got %0d expected 3", level_o);
    end
    rd_en_i = 1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rd_data_o !== a[i]) begin
        n_fail++;
        $display("FAIL basic_pop%0d: got %h expected %h", i, rd_data_o, a[i]);
      end
      cyc();
    end
    rd_en_i = 0;
    n_tests++;
    if (empty_o !== 1'b1 || level_o !== 5'd0) begin
      n_fail++;
      $display("FAIL basic_empty: got empty=%b lvl=%0d expected empty=1 lvl=0", empty_o, level_o);
    end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] head;
    wr_en_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data_i = $urandom;
      if (i == 0) head = wr_data_i;
      cyc();
    end
    wr_en_i = 0;
    n_tests++;
    if (full_o !== 1'b1 || level_o !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b lvl=%0d expected full=1 lvl=16", full_o, level_o);
    end
    wr_en_i = 1; wr_data_i = $urandom;
    cyc();
    wr_en_i = 0;
    n_tests++;
    if (overflow_o !== 1'b1 || level_o !== 5'd16 || rd_data_o !== head) begin
      n_fail++;
      $display("FAIL overflow_set: got ov=%b lvl=%0d rd=%h expected ov=1 lvl=16 rd=%h", overflow_o, level_o, rd_data_o, head);
    end
    clr_err_i = 1;
    cyc();
    clr_err_i = 0;
    n_tests++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b expected 0", overflow_o);
    end
  endtask

  // Expects a full FIFO from the previous scenario; drains it afterwards.
  task automatic test_full_rw();
    rd_en_i = 1; wr_en_i = 1;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (rd_data_o !== m_q[0]) begin
        n_fail++;
        $display("FAIL full_rw_data%0d: got %h expected %h", i, rd_data_o, m_q[0]);
      end
      wr_data_i = $urandom;
      cyc();
      n_tests++;
      if (level_o !== 5'd16 || full_o !== 1'b1 || overflow_o !== 1'b0) begin
        n_fail++;
        $display("FAIL full_rw_level%0d: got lvl=%0d full=%b ov=%b expected lvl=16 full=1 ov=0", i, level_o, full_o, overflow_o);
      end
    end
    wr_en_i = 0;
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if (rd_data_o !== m_q[0]) begin
        n_fail++;
        $display("FAIL drain_order%0d: got %h expected %h", i, rd_data_o, m_q[0]);
      end
      cyc();
    end
    rd_en_i = 0;
  endtask

  task automatic test_underflow();
    logic [31:0] w;
    w = $urandom;
    rd_en_i = 1; wr_en_i = 1; wr_data_i = w;
    cyc();
    idle_inputs();
    n_tests++;
    if (underflow_o !== 1'b1 || level_o !== 5'd1 || rd_data_o !== w) begin
      n_fail++;
      $display("FAIL underflow_rw: got un=%b lvl=%0d rd=%h expected un=1 lvl=1 rd=%h", underflow_o, level_o, rd_data_o, w);
    end
    rd_en_i = 1; clr_err_i = 1;
    cyc();
    idle_inputs();
  endtask

  task automatic test_watermarks();
    afull_thr_i = 5'd12; aempty_thr_i = 5'd2;
    wr_en_i = 1;
    for (int k = 1; k <= DEPTH; k++) begin
      wr_data_i = $urandom;
      cyc();
      n_tests++;
      if (almost_full_o !== (k >= 12) || almost_empty_o !== (k <= 2) || level_o !== 5'(k)) begin
        n_fail++;
        $display("FAIL wm_up%0d: got af=%b ae=%b lvl=%0d expected af=%b ae=%b", k, almost_full_o, almost_empty_o, level_o, k >= 12, k <= 2);
      end
    end
    wr_en_i = 0; rd_en_i = 1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      cyc();
      n_tests++;
      if (almost_full_o !== (k >= 12) || almost_empty_o !== (k <= 2) || level_o !== 5'(k)) begin
        n_fail++;
        $display("FAIL wm_down%0d: got af=%b ae=%b lvl=%0d expected af=%b ae=%b", k, almost_full_o, almost_empty_o, level_o, k >= 12, k <= 2);
      end
    end
    rd_en_i = 0;
    afull_thr_i = 5'd0; aempty_thr_i = 5'd20;
    cyc();
    n_tests++;
    if (almost_full_o !== 1'b1 || almost_empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wm_extreme_empty: got af=%b ae=%b expected af=1 ae=1", almost_full_o, almost_empty_o);
    end
    wr_en_i = 1;
    for (int k = 0; k < DEPTH; k++) begin wr_data_i = $urandom; cyc(); end
    wr_en_i = 0;
    n_tests++;
    if (almost_full_o !== 1'b1 || almost_empty_o !== 1'b1 || full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wm_extreme_full: got af=%b ae=%b full=%b expected 1 1 1", almost_full_o, almost_empty_o, full_o);
    end
    afull_thr_i = 5'd12; aempty_thr_i = 5'd2;
  endtask

  task automatic test_flush();
    flush_i = 1; clr_err_i = 1; cyc(); idle_inputs();
    wr_en_i = 1;
    for (int k = 0; k < 9; k++) begin wr_data_i = $urandom; cyc(); end
    n_tests++;
    if (level_o !== 5'd9) begin
      n_fail++;
      $display("FAIL flush_pre_level: got %0d expected 9", level_o);
    end
    flush_i = 1; wr_data_i = $urandom;
    cyc();
    idle_inputs();
    n_tests++;
    if (level_o !== 5'd0 || empty_o !== 1'b1 || almost_empty_o !== 1'b1 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: got lvl=%0d e=%b ae=%b ov=%b un=%b expected 0 1 1 0 0", level_o, empty_o, almost_empty_o, overflow_o, underflow_o);
    end
    rd_en_i = 1; cyc(); idle_inputs();
    flush_i = 1; rd_en_i = 1; cyc(); idle_inputs();
    n_tests++;
    if (underflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_keeps_err: got un=%b expected 1", underflow_o);
    end
    rd_en_i = 1; clr_err_i = 1; cyc(); idle_inputs();
    n_tests++;
    if (underflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_set_wins: got un=%b expected 1", underflow_o);
    end
    clr_err_i = 1; cyc(); idle_inputs();
    n_tests++;
    if (underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: got un=%b expected 0", underflow_o);
    end
  endtask

  task automatic test_reset_mid();
    wr_en_i = 1;
    for (int k = 0; k < 5; k++) begin wr_data_i = $urandom; cyc(); end
    rd_en_i = 1;
    reset_i = 1;
    #2;
    n_tests++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || level_o !== 5'd0 || almost_empty_o !== 1'b1 ||
        almost_full_o !== 1'b0 || rd_data_o !== 32'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got e=%b f=%b lvl=%0d ae=%b af=%b rd=%h ov=%b un=%b expected reset values",
               empty_o, full_o, level_o, almost_empty_o, almost_full_o, rd_data_o, overflow_o, underflow_o);
    end
    idle_inputs();
    #1;
    reset_i = 0;
    model_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      wr_en_i   = ($urandom_range(0, 99) < 55);
      rd_en_i   = ($urandom_range(0, 99) < 50);
      flush_i   = ($urandom_range(0, 99) < 3);
      clr_err_i = ($urandom_range(0, 99) < 6);
      wr_data_i = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        afull_thr_i  = 5'($urandom_range(0, 17));
        aempty_thr_i = 5'($urandom_range(0, 17));
      end
      cyc();
      n_tests++;
      if (level_o !== 5'(m_q.size()) || empty_o !== (m_q.size() == 0) || full_o !== (m_q.size() == DEPTH) ||
          rd_data_o !== m_rd || almost_full_o !== m_af || almost_empty_o !== m_ae ||
          overflow_o !== m_ovf || underflow_o !== m_udf) begin
        n_fail++;
        $display("FAIL random%0d: got lvl=%0d e=%b f=%b rd=%h af=%b ae=%b ov=%b un=%b expected lvl=%0d rd=%h af=%b ae=%b ov=%b un=%b",
                 c, level_o, empty_o, full_o, rd_data_o, almost_full_o, almost_empty_o, overflow_o, underflow_o,
                 m_q.size(), m_rd, m_af, m_ae, m_ovf, m_udf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_rw();
    test_underflow();
    test_watermarks();
    test_reset();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
